// File: rtl/model_transformer_matrix_receiver.sv
// Receives an L x X matrix one element at a time using a request/strobe handshake.
// Accepted elements are stored in a row-major buffer, summed, and can be read back by index.
module model_transformer_matrix_receiver #(
    parameter int DATA_SIZE = 64,
    parameter int L_MAX     = 4,
    parameter int X_MAX     = 4
) (
    input  logic                 CLK,
    input  logic                 RST,
    input  logic                 START,
    output logic                 READY,
    output logic                 ERROR,
    input  logic [DATA_SIZE-1:0] SIZE_L_IN,
    input  logic [DATA_SIZE-1:0] SIZE_X_IN,
    input  logic [DATA_SIZE-1:0] DATA_IN,
    input  logic                 DATA_IN_L_ENABLE,
    input  logic                 DATA_IN_X_ENABLE,
    output logic                 DATA_OUT_L_ENABLE,
    output logic                 DATA_OUT_X_ENABLE,
    output logic [DATA_SIZE-1:0] SUM_OUT,
    input  logic [DATA_SIZE-1:0] RD_L,
    input  logic [DATA_SIZE-1:0] RD_X,
    output logic [DATA_SIZE-1:0] RD_DATA
);

    localparam int DEPTH = L_MAX * X_MAX;
    localparam int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int IW    = (L_MAX > 1) ? $clog2(L_MAX) : 1;
    localparam int JW    = (X_MAX > 1) ? $clog2(X_MAX) : 1;

    typedef enum logic [1:0] {
        IDLE,
        REQUEST,
        WAIT_ELEMENT,
        ENDER
    } state_t;

    state_t               state;
    logic [DATA_SIZE-1:0] size_l;
    logic [DATA_SIZE-1:0] size_x;
    logic [IW-1:0]        row_idx;
    logic [JW-1:0]        col_idx;
    logic [DATA_SIZE-1:0] buffer [DEPTH];

    logic                 size_bad;
    logic                 last_col;
    logic                 last_row;
    logic                 marker_bad;
    logic                 accept;
    logic                 rd_in_range;
    logic [AW-1:0]        wr_addr;
    logic [AW-1:0]        rd_addr;

    assign size_bad = (SIZE_L_IN == '0) || (SIZE_X_IN == '0) ||
                      (SIZE_L_IN > DATA_SIZE'(L_MAX)) || (SIZE_X_IN > DATA_SIZE'(X_MAX));

    assign last_col   = (DATA_SIZE'(col_idx) == size_x - DATA_SIZE'(1));
    assign last_row   = (DATA_SIZE'(row_idx) == size_l - DATA_SIZE'(1));
    assign marker_bad = (DATA_IN_L_ENABLE != (col_idx == '0));
    assign accept     = (state == WAIT_ELEMENT) && DATA_IN_X_ENABLE;

    // Buffer rows are X_MAX apart regardless of the active X, so readback indexing is fixed.
    assign wr_addr     = AW'(row_idx) * AW'(X_MAX) + AW'(col_idx);
    assign rd_in_range = (RD_L < DATA_SIZE'(L_MAX)) && (RD_X < DATA_SIZE'(X_MAX));
    assign rd_addr     = AW'(RD_L) * AW'(X_MAX) + AW'(RD_X);

    always_ff @(posedge CLK) begin
        if (accept) begin
            buffer[wr_addr] <= DATA_IN;
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            RD_DATA <= '0;
        end else begin
            RD_DATA <= rd_in_range ? buffer[rd_addr] : '0;
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state             <= IDLE;
            READY             <= 1'b0;
            ERROR             <= 1'b0;
            DATA_OUT_L_ENABLE <= 1'b0;
            DATA_OUT_X_ENABLE <= 1'b0;
            SUM_OUT           <= '0;
            size_l            <= '0;
            size_x            <= '0;
            row_idx           <= '0;
            col_idx           <= '0;
        end else begin
            READY             <= 1'b0;
            DATA_OUT_L_ENABLE <= 1'b0;
            DATA_OUT_X_ENABLE <= 1'b0;
            case (state)
                IDLE: begin
                    if (START) begin
                        size_l  <= SIZE_L_IN;
                        size_x  <= SIZE_X_IN;
                        SUM_OUT <= '0;
                        row_idx <= '0;
                        col_idx <= '0;
                        if (size_bad) begin
                            ERROR <= 1'b1;
                            READY <= 1'b1;
                        end else begin
                            ERROR <= 1'b0;
                            state <= REQUEST;
                        end
                    end
                end
                REQUEST: begin
                    if (DATA_IN_X_ENABLE) begin
                        ERROR <= 1'b1;
                    end
                    DATA_OUT_L_ENABLE <= 1'b1;
                    DATA_OUT_X_ENABLE <= 1'b1;
                    state             <= WAIT_ELEMENT;
                end
                WAIT_ELEMENT: begin
                    // No request is re-issued while waiting; the source may stall indefinitely.
                    if (DATA_IN_X_ENABLE) begin
                        SUM_OUT <= SUM_OUT + DATA_IN;
                        if (marker_bad) begin
                            ERROR <= 1'b1;
                        end
                        if (!last_col) begin
                            col_idx           <= col_idx + JW'(1);
                            DATA_OUT_X_ENABLE <= 1'b1;
                        end else if (!last_row) begin
                            row_idx           <= row_idx + IW'(1);
                            col_idx           <= '0;
                            DATA_OUT_L_ENABLE <= 1'b1;
                            DATA_OUT_X_ENABLE <= 1'b1;
                        end else begin
                            state <= ENDER;
                        end
                    end
                end
                ENDER: begin
                    READY <= 1'b1;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: doc/model_transformer_matrix_receiver.md
MODEL_TRANSFORMER_MATRIX_RECEIVER -- requirements
Module: model_transformer_matrix_receiver

Interface
REQ-001 Parameter DATA_SIZE, default 64: data and size word width.
REQ-002 Parameter L_MAX, default 4: maximum row count accepted.
REQ-003 Parameter X_MAX, default 4: maximum column count accepted; buffer depth is L_MAX*X_MAX.
REQ-004 CLK  in  1  single clock; all state updates on rising edge.
REQ-005 RST  in  1  reset, asynchronous, active-high.
REQ-006 START  in  1  begin receiving one L x X matrix.
REQ-007 READY  out  1  one-cycle pulse when reception completes or is rejected.
REQ-008 ERROR  out  1  sticky protocol/size error flag for the current or last transfer.
REQ-009 SIZE_L_IN  in  DATA_SIZE  row count L, sampled on START.
REQ-010 SIZE_X_IN  in  DATA_SIZE  column count X, sampled on START.
REQ-011 DATA_IN  in  DATA_SIZE  matrix element from the stimulus side.
REQ-012 DATA_IN_L_ENABLE  in  1  marks an element as the first element of a row.
REQ-013 DATA_IN_X_ENABLE  in  1  element-valid strobe; DATA_IN is accepted in each cycle this is high.
REQ-014 DATA_OUT_L_ENABLE  out  1  one-cycle request for the first element of the next row.
REQ-015 DATA_OUT_X_ENABLE  out  1  one-cycle request for the next element.
REQ-016 SUM_OUT  out  DATA_SIZE  modulo-2^DATA_SIZE sum of all accepted elements.
REQ-017 RD_L  in  DATA_SIZE  readback row index.
REQ-018 RD_X  in  DATA_SIZE  readback column index.
REQ-019 RD_DATA  out  DATA_SIZE  registered readback data.

Function
REQ-020 FSM states: IDLE, REQUEST, WAIT_ELEMENT, ENDER.
REQ-021 In IDLE, START=1 latches L and X, clears SUM_OUT and ERROR, and resets the indices to i=0, j=0.
REQ-022 If L=0, X=0, L>L_MAX or X>X_MAX when START is sampled, ERROR=1, READY pulses in the next cycle, and the FSM stays in IDLE.
REQ-023 For valid sizes, the FSM enters REQUEST; in the following cycle it asserts DATA_OUT_L_ENABLE=1 and DATA_OUT_X_ENABLE=1 for one cycle to request element (0,0), then enters WAIT_ELEMENT.
REQ-024 In WAIT_ELEMENT, DATA_IN_X_ENABLE=1 writes DATA_IN to buffer[i*X_MAX+j] and adds it to SUM_OUT, truncating the carry.
REQ-025 DATA_IN_L_ENABLE must equal (j==0) at each accepted element; on a mismatch the element is still stored and ERROR is set.
REQ-026 After an accept with j<X-1: j increments, and DATA_OUT_X_ENABLE pulses alone in the next cycle.
REQ-027 After an accept with j=X-1 and i<L-1: i increments, j clears, and DATA_OUT_L_ENABLE and DATA_OUT_X_ENABLE both pulse in the next cycle.
REQ-028 After accepting the last element (i=L-1, j=X-1), the FSM enters ENDER; READY pulses in the next cycle, then the FSM returns to IDLE.
REQ-029 Request-to-accept latency is unbounded; the FSM waits in WAIT_ELEMENT indefinitely with no request re-issued.
REQ-030 DATA_IN_X_ENABLE outside WAIT_ELEMENT is ignored and sets ERROR only when the FSM is in REQUEST.
REQ-031 START outside IDLE is ignored.
REQ-032 At most one element is accepted per cycle, and at most one request pulse is outstanding at a time.
REQ-033 Readback: RD_DATA equals buffer[RD_L*X_MAX+RD_X] one cycle after the address is presented, and is 0 if RD_L>=L_MAX or RD_X>=X_MAX.
REQ-034 Readback is legal in any state; reading an entry written in the same cycle returns the old value.
REQ-035 SUM_OUT and ERROR hold their values from the end of a transfer until the next accepted START.

Reset
REQ-036 RST=1 forces the following immediately, regardless of CLK: state IDLE; READY=0, ERROR=0, DATA_OUT_L_ENABLE=0, DATA_OUT_X_ENABLE=0; SUM_OUT=0, RD_DATA=0; i=0, j=0; latched sizes 0.
REQ-037 Buffer contents are not cleared by reset.
REQ-038 Reset mid-transfer abandons the transfer; no READY pulse is issued; the next START behaves as from power-up.

Verification
REQ-039 Scenario, 2x3 matrix: L=2, X=3, elements 1..6 each sent one cycle after its request -> request pattern L+X, X, X, L+X, X, X; READY pulse once; SUM_OUT=21; ERROR=0; RD_L=1, RD_X=2 -> RD_DATA=6.
REQ-040 Scenario, bad size: START with L=5 (L_MAX=4), X=2 -> READY pulse one cycle later; ERROR=1; no request pulses.
REQ-041 Scenario, row-marker error: 1x2 matrix with DATA_IN_L_ENABLE=0 on element (0,0) -> ERROR=1; transfer still completes with READY.
REQ-042 Scenario, stall and wrap: 4x4 matrix with all elements 2^DATA_SIZE-1 and a 10-cycle stall before each element -> SUM_OUT=2^DATA_SIZE-16; no duplicate requests issued during stalls.
REQ-043 Scenario, mid-transfer reset: RST asserted after 3 of 6 elements, then a 1x1 transfer of value 7 -> no READY from the first transfer; SUM_OUT=7 after the second.
REQ-044 Scenario, START while busy: second START during WAIT_ELEMENT with different sizes -> ignored; the original L and X are honoured.
